// File: rtl/axi_lite_pkg.sv
// rtl/axi_lite_pkg.sv - shared types and constants for the AXI-lite DRAM responder
package axi_lite_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } resp_t;

    typedef logic [1:0] rd_state_t;
    localparam rd_state_t RD_IDLE = 2'd0;
    localparam rd_state_t RD_WAIT = 2'd1;
    localparam rd_state_t RD_RESP = 2'd2;

    typedef logic [1:0] wr_state_t;
    localparam wr_state_t WR_IDLE = 2'd0;
    localparam wr_state_t WR_WAIT = 2'd1;
    localparam wr_state_t WR_RESP = 2'd2;

    localparam logic [31:0] DRAM_BASE = 32'h0001_0000;

    // Latency counter width; comfortably covers any practical RD_LAT/WR_LAT.
    localparam int CNT_W = 16;

endpackage

// File: rtl/dram_lat_cnt.sv
// rtl/dram_lat_cnt.sv - one-shot down counter producing a done pulse after load_val+1 cycles
module dram_lat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt;
    logic         busy;

    // done is high for the one cycle in which a running count has reached zero.
    assign done = busy && (cnt == '0);

    // Load on start, count down while busy, and go idle on the done cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (start) begin
            busy <= 1'b1;
            cnt  <= load_val;
        end else if (done) begin
            busy <= 1'b0;
        end else if (busy) begin
            cnt  <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/axi_lite_dram_slave.sv
// rtl/axi_lite_dram_slave.sv - AXI-lite responder serving a word array after a fixed latency
module axi_lite_dram_slave
    import axi_lite_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 64,
    parameter int                DEPTH     = 256,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(DRAM_BASE),
    parameter int                RD_LAT    = 4,
    parameter int                WR_LAT    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              AR_VALID,
    input  logic [ADDR_W-1:0] AR_ADDR,
    output logic              AR_READY,
    output logic              R_VALID,
    output logic [DATA_W-1:0] R_DATA,
    output logic [1:0]        R_RESP,
    input  logic              R_READY,
    input  logic              AW_VALID,
    input  logic [ADDR_W-1:0] AW_ADDR,
    output logic              AW_READY,
    input  logic              W_VALID,
    input  logic [DATA_W-1:0] W_DATA,
    output logic              W_READY,
    output logic              B_VALID,
    output logic [1:0]        B_RESP,
    input  logic              B_READY
);

    localparam int IDX_W = $clog2(DEPTH);

    // Below-base addresses wrap to a huge offset, but the explicit compare flags them first.
    function automatic logic addr_err(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] off;
        off = a - BASE_ADDR;
        return (a < BASE_ADDR) || (a[1:0] != 2'b00) || ((off >> 2) >= ADDR_W'(DEPTH));
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] off;
        off = a - BASE_ADDR;
        return off[IDX_W+1:2];
    endfunction

    logic [DATA_W-1:0] mem [DEPTH];

    rd_state_t         rd_state;
    logic [IDX_W-1:0]  rd_idx;
    logic              rd_err;
    logic              rd_done;
    logic [DATA_W-1:0] rd_word;

    wr_state_t         wr_state;
    logic [IDX_W-1:0]  wr_idx;
    logic              wr_err;
    logic [DATA_W-1:0] wr_data;
    logic              aw_got;
    logic              w_got;
    logic              wr_done;
    logic              wr_commit;

    logic ar_hs;
    logic aw_hs;
    logic w_hs;
    logic aw_have;
    logic w_have;
    logic wr_start;

    assign ar_hs    = AR_VALID && AR_READY;
    assign aw_hs    = AW_VALID && AW_READY;
    assign w_hs     = W_VALID && W_READY;
    assign aw_have  = aw_got || aw_hs;
    assign w_have   = w_got || w_hs;
    assign wr_start = (wr_state == WR_IDLE) && aw_have && w_have;

    assign wr_commit = (wr_state == WR_WAIT) && wr_done && !wr_err;

    // Write-first: a commit landing on the word being sampled is forwarded to the read.
    assign rd_word = (wr_commit && (wr_idx == rd_idx)) ? wr_data : mem[rd_idx];

    dram_lat_cnt #(.W(CNT_W)) u_rd_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (ar_hs),
        .load_val (CNT_W'(RD_LAT - 1)),
        .done     (rd_done)
    );

    dram_lat_cnt #(.W(CNT_W)) u_wr_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (wr_start),
        .load_val (CNT_W'(WR_LAT - 1)),
        .done     (wr_done)
    );

    // Array storage: single write port, contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_commit) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // Read channel: accept address, wait out the latency, then hold the response until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state <= RD_IDLE;
            rd_idx   <= '0;
            rd_err   <= 1'b0;
            AR_READY <= 1'b0;
            R_VALID  <= 1'b0;
            R_DATA   <= '0;
            R_RESP   <= OKAY;
        end else begin
            case (rd_state)
                RD_IDLE: begin
                    if (ar_hs) begin
                        rd_idx   <= addr_idx(AR_ADDR);
                        rd_err   <= addr_err(AR_ADDR);
                        AR_READY <= 1'b0;
                        rd_state <= RD_WAIT;
                    end else begin
                        AR_READY <= 1'b1;
                    end
                end
                RD_WAIT: begin
                    if (rd_done) begin
                        R_DATA   <= rd_err ? '0 : rd_word;
                        R_RESP   <= rd_err ? SLVERR : OKAY;
                        R_VALID  <= 1'b1;
                        rd_state <= RD_RESP;
                    end
                end
                RD_RESP: begin
                    if (R_READY) begin
                        R_VALID  <= 1'b0;
                        R_DATA   <= '0;
                        R_RESP   <= OKAY;
                        AR_READY <= 1'b1;
                        rd_state <= RD_IDLE;
                    end
                end
                default: begin
                    rd_state <= RD_IDLE;
                end
            endcase
        end
    end

    // Write channel: collect AW and W in any order, wait, commit, then hold the response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state <= WR_IDLE;
            wr_idx   <= '0;
            wr_err   <= 1'b0;
            wr_data  <= '0;
            aw_got   <= 1'b0;
            w_got    <= 1'b0;
            AW_READY <= 1'b0;
            W_READY  <= 1'b0;
            B_VALID  <= 1'b0;
            B_RESP   <= OKAY;
        end else begin
            case (wr_state)
                WR_IDLE: begin
                    if (aw_hs) begin
                        wr_idx <= addr_idx(AW_ADDR);
                        wr_err <= addr_err(AW_ADDR);
                    end
                    if (w_hs) begin
                        wr_data <= W_DATA;
                    end
                    AW_READY <= !aw_have;
                    W_READY  <= !w_have;
                    if (wr_start) begin
                        aw_got   <= 1'b0;
                        w_got    <= 1'b0;
                        wr_state <= WR_WAIT;
                    end else begin
                        aw_got   <= aw_have;
                        w_got    <= w_have;
                    end
                end
                WR_WAIT: begin
                    if (wr_done) begin
                        B_VALID  <= 1'b1;
                        B_RESP   <= wr_err ? SLVERR : OKAY;
                        wr_state <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (B_READY) begin
                        B_VALID  <= 1'b0;
                        B_RESP   <= OKAY;
                        AW_READY <= 1'b1;
                        W_READY  <= 1'b1;
                        wr_state <= WR_IDLE;
                    end
                end
                default: begin
                    wr_state <= WR_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_dram_slave.sv
// tb/tb_axi_lite_dram_slave.sv - self-checking bench for axi_lite_dram_slave
module tb_axi_lite_dram_slave;

    localparam int          ADDR_W = 32;
    localparam int          DATA_W = 64;
    localparam int          DEPTH  = 256;
    localparam int          RD_LAT = 4;
    localparam int          WR_LAT = 4;
    localparam logic [31:0] BASE   = 32'h0001_0000;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              AR_VALID, AR_READY, R_VALID, R_READY;
    logic [ADDR_W-1:0] AR_ADDR, AW_ADDR;
    logic [DATA_W-1:0] R_DATA, W_DATA;
    logic [1:0]        R_RESP, B_RESP;
    logic              AW_VALID, AW_READY, W_VALID, W_READY, B_VALID, B_READY;

    always #5 clk = ~clk;

    axi_lite_dram_slave #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH),
        .BASE_ADDR(BASE), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .AR_VALID(AR_VALID), .AR_ADDR(AR_ADDR), .AR_READY(AR_READY),
        .R_VALID(R_VALID), .R_DATA(R_DATA), .R_RESP(R_RESP), .R_READY(R_READY),
        .AW_VALID(AW_VALID), .AW_ADDR(AW_ADDR), .AW_READY(AW_READY),
        .W_VALID(W_VALID), .W_DATA(W_DATA), .W_READY(W_READY),
        .B_VALID(B_VALID), .B_RESP(B_RESP), .B_READY(B_READY)
    );

    int errors = 0;
    int checks = 0;

    logic [63:0] model_mem   [DEPTH];
    bit          model_known [DEPTH];

    function automatic bit m_err(input logic [31:0] a);
        if (a < BASE) return 1'b1;
        if (a % 4 != 0) return 1'b1;
        return ((a - BASE) / 4) >= DEPTH;
    endfunction

    function automatic int m_idx(input logic [31:0] a);
        return int'((a - BASE) / 4);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ar_ready"}, 64'(AR_READY), 64'(0));
        check({tag, "_aw_ready"}, 64'(AW_READY), 64'(0));
        check({tag, "_w_ready"},  64'(W_READY),  64'(0));
        check({tag, "_r_valid"},  64'(R_VALID),  64'(0));
        check({tag, "_r_data"},   64'(R_DATA),   64'(0));
        check({tag, "_r_resp"},   64'(R_RESP),   64'(0));
        check({tag, "_b_valid"},  64'(B_VALID),  64'(0));
        check({tag, "_b_resp"},   64'(B_RESP),   64'(0));
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [63:0] data,
                            input int aw_dly, input int w_dly, input int b_hold);
        bit aw_done = 1'b0;
        bit w_done  = 1'b0;
        bit aw_fire, w_fire;
        bit exp_err;
        int t   = 0;
        int lat = 0;
        exp_err = m_err(addr);
        AW_ADDR = addr;
        W_DATA  = data;
        while (!(aw_done && w_done) && t < 50) begin
            AW_VALID = !aw_done && (t >= aw_dly);
            W_VALID  = !w_done && (t >= w_dly);
            if (w_done && !aw_done) begin
                check("gap_w_ready",  64'(W_READY),  64'(0));
                check("gap_aw_ready", 64'(AW_READY), 64'(1));
            end
            if (aw_done && !w_done) begin
                check("gap_aw_ready", 64'(AW_READY), 64'(0));
                check("gap_w_ready",  64'(W_READY),  64'(1));
            end
            aw_fire = AW_VALID && AW_READY;
            w_fire  = W_VALID && W_READY;
            tick();
            t++;
            if (aw_fire) aw_done = 1'b1;
            if (w_fire)  w_done  = 1'b1;
        end
        AW_VALID = 1'b0;
        W_VALID  = 1'b0;
        check("wr_handshake_done", 64'(aw_done && w_done), 64'(1));
        while (!B_VALID && lat < 50) begin
            tick();
            lat++;
        end
        check("b_latency", 64'(lat), 64'(WR_LAT));
        check("b_resp", 64'(B_RESP), exp_err ? 64'h2 : 64'h0);
        repeat (b_hold) begin
            tick();
            check("b_hold_valid", 64'(B_VALID), 64'(1));
            check("b_hold_resp",  64'(B_RESP), exp_err ? 64'h2 : 64'h0);
        end
        B_READY = 1'b1;
        tick();
        B_READY = 1'b0;
        check("b_cleared",      64'(B_VALID),  64'(0));
        check("aw_ready_after", 64'(AW_READY), 64'(1));
        check("w_ready_after",  64'(W_READY),  64'(1));
        if (!exp_err) begin
            model_mem[m_idx(addr)]   = data;
            model_known[m_idx(addr)] = 1'b1;
        end
    endtask

    task automatic do_read(input logic [31:0] addr, input int r_hold);
        bit          exp_err;
        logic [63:0] exp_data;
        int t   = 0;
        int lat = 0;
        exp_err  = m_err(addr);
        exp_data = exp_err ? 64'h0 : model_mem[m_idx(addr)];
        AR_ADDR  = addr;
        AR_VALID = 1'b1;
        while (!AR_READY && t < 50) begin
            tick();
            t++;
        end
        check("ar_ready_seen", 64'(AR_READY), 64'(1));
        tick();
        AR_VALID = 1'b0;
        while (!R_VALID && lat < 50) begin
            tick();
            lat++;
        end
        check("r_latency", 64'(lat), 64'(RD_LAT));
        check("r_resp", 64'(R_RESP), exp_err ? 64'h2 : 64'h0);
        check("r_data", R_DATA, exp_data);
        repeat (r_hold) begin
            tick();
            check("r_hold_valid",    64'(R_VALID),  64'(1));
            check("r_hold_data",     R_DATA,        exp_data);
            check("r_hold_ar_ready", 64'(AR_READY), 64'(0));
        end
        R_READY = 1'b1;
        tick();
        R_READY = 1'b0;
        check("r_cleared_valid", 64'(R_VALID),  64'(0));
        check("r_cleared_data",  64'(R_DATA),   64'(0));
        check("ar_ready_after",  64'(AR_READY), 64'(1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] d_old, d_new, d_a, d_b;
        logic [31:0] addr;
        int          idx;

        rst_n = 1'b0;
        AR_VALID = 1'b0; AR_ADDR = '0; R_READY = 1'b0;
        AW_VALID = 1'b0; AW_ADDR = '0; W_VALID = 1'b0; W_DATA = '0; B_READY = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            model_known[i] = 1'b0;
            model_mem[i]   = '0;
        end

        // Reset state and READY rising one cycle after release.
        repeat (3) tick();
        check_outputs_zero("reset");
        rst_n = 1'b1;
        check("release_ar_ready_low", 64'(AR_READY), 64'(0));
        tick();
        check("release_ar_ready", 64'(AR_READY), 64'(1));
        check("release_aw_ready", 64'(AW_READY), 64'(1));
        check("release_w_ready",  64'(W_READY),  64'(1));

        // Write then read back, AW and W together.
        do_write(32'h0001_0008, 64'hDEAD_BEEF_0123_4567, 0, 0, 0);
        do_read(32'h0001_0008, 0);

        // Split write: W first, AW three cycles later.
        do_write(32'h0001_0010, {$urandom, $urandom}, 3, 0, 1);
        // AW first, W two cycles later.
        do_write(32'h0001_0018, {$urandom, $urandom}, 0, 2, 2);

        // Read backpressure.
        do_read(32'h0001_0010, 5);
        do_read(32'h0001_0018, 2);

        // Error responses: past the end, below base (aliases to index 255), misaligned.
        do_read(32'h0001_0400, 0);
        do_write(32'h0001_03FC, 64'h1111_2222_3333_4444, 0, 0, 0);
        do_write(32'h0000_FFFC, 64'hBAD0_BAD0_BAD0_BAD0, 0, 0, 0);
        do_read(32'h0001_03FC, 0);
        do_write(32'h0001_0004, 64'h5555_6666_7777_8888, 0, 0, 0);
        do_write(32'h0001_0006, 64'hBAD1_BAD1_BAD1_BAD1, 1, 0, 0);
        do_read(32'h0001_0004, 0);
        do_read(32'h0001_0006, 1);

        // Collision on index 5: sample and commit on the same edge.
        d_old = 64'h0A0A_0A0A_0A0A_0A0A;
        d_new = 64'h5B5B_5B5B_C0DE_C0DE;
        do_write(32'h0001_0014, d_old, 0, 0, 0);
        AW_ADDR = 32'h0001_0014; W_DATA = d_new; AR_ADDR = 32'h0001_0014;
        AW_VALID = 1'b1; W_VALID = 1'b1; AR_VALID = 1'b1;
        tick();
        AW_VALID = 1'b0; W_VALID = 1'b0; AR_VALID = 1'b0;
        repeat (RD_LAT) tick();
        check("coll_r_valid", 64'(R_VALID), 64'(1));
        check("coll_b_valid", 64'(B_VALID), 64'(1));
        check("coll_r_data",  R_DATA,       d_new);
        R_READY = 1'b1; B_READY = 1'b1;
        tick();
        R_READY = 1'b0; B_READY = 1'b0;
        model_mem[5] = d_new;
        do_read(32'h0001_0014, 0);

        // Reset mid-transaction: pending read response and uncommitted write are discarded.
        d_a = 64'hAAAA_0000_AAAA_0009;
        d_b = 64'hBBBB_0000_BBBB_0009;
        do_write(32'h0001_0024, d_a, 0, 0, 0);
        AR_ADDR = 32'h0001_0008; AR_VALID = 1'b1;
        tick();
        AR_VALID = 1'b0;
        repeat (RD_LAT) tick();
        check("mid_r_pending", 64'(R_VALID), 64'(1));
        AW_ADDR = 32'h0001_0024; W_DATA = d_b; AW_VALID = 1'b1; W_VALID = 1'b1;
        tick();
        AW_VALID = 1'b0; W_VALID = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        check_outputs_zero("mid_reset");
        tick();
        rst_n = 1'b1;
        check("mid_release_aw_ready_low", 64'(AW_READY), 64'(0));
        tick();
        check("mid_release_ar_ready", 64'(AR_READY), 64'(1));
        check("mid_release_aw_ready", 64'(AW_READY), 64'(1));
        check("mid_release_w_ready",  64'(W_READY),  64'(1));
        do_read(32'h0001_0024, 0);
        do_read(32'h0001_0008, 0);

        // Randomized mix of reads and writes against the array model.
        for (int n = 0; n < 30; n++) begin
            idx = int'($urandom_range(0, DEPTH - 1));
            case ($urandom_range(0, 6))
                0, 1, 2, 3: addr = BASE + 32'(idx) * 4;
                4:          addr = $urandom_range(0, 32'h0000_FFFF);
                5:          addr = BASE + 32'(idx) * 4 + $urandom_range(1, 3);
                default:    addr = BASE + (32'(DEPTH) + $urandom_range(0, 1000)) * 4;
            endcase
            if ($urandom_range(0, 1) == 0 || (!m_err(addr) && !model_known[m_idx(addr)])) begin
                do_write(addr, {$urandom, $urandom}, int'($urandom_range(0, 3)),
                         int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            end else begin
                do_read(addr, int'($urandom_range(0, 3)));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
